load_store_unit: RTL

//  MEM-stage consumer of the decoded control word: accepts one load/store per request from EX/MEM,

---
 rtl/rv32i_types.sv | 74 +++++++
 rtl/load_data_align.sv | 36 +++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types for the memory stage.
//   rv32i_opcode   : major opcodes
//   load_funct3_t  : load width/sign selector
//   store_funct3_t : store width selector
//   lsu_state_t    : load/store unit FSM states
// Helpers decode alignment, byte enables and lane-replicated store data.
package rv32i_types;

    typedef enum logic [6:0] {
        OpLui   = 7'b0110111,
        OpAuipc = 7'b0010111,
        OpJal   = 7'b1101111,
        OpJalr  = 7'b1100111,
        OpBr    = 7'b1100011,
        OpLoad  = 7'b0000011,
        OpStore = 7'b0100011,
        OpImm   = 7'b0010011,
        OpReg   = 7'b0110011,
        OpCsr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        Lb  = 3'b000,
        Lh  = 3'b001,
        Lw  = 3'b010,
        Lbu = 3'b100,
        Lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        Sb = 3'b000,
        Sh = 3'b001,
        Sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } lsu_state_t;

    // Unknown widths fall back to word rules.
    function automatic logic is_misaligned(logic is_store, logic [2:0] funct3,
                                           logic [1:0] addr_lo);
        logic byte_op;
        logic half_op;
        byte_op = is_store ? (funct3 == Sb) : ((funct3 == Lb) || (funct3 == Lbu));
        half_op = is_store ? (funct3 == Sh) : ((funct3 == Lh) || (funct3 == Lhu));
        if (byte_op) begin
            return 1'b0;
        end else if (half_op) begin
            return addr_lo[0];
        end
        return addr_lo != 2'b00;
    endfunction

    function automatic logic [3:0] store_mbe(logic [2:0] funct3, logic [1:0] addr_lo);
        case (funct3)
            Sb:      return 4'b0001 << addr_lo;
            Sh:      return 4'b0011 << addr_lo;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow data across all lanes so memory can pick by byte enable.
    function automatic logic [31:0] store_wdata(logic [2:0] funct3, logic [31:0] wdata);
        case (funct3)
            Sb:      return {4{wdata[7:0]}};
            Sh:      return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_data_align.sv
// Load data alignment: selects the addressed lane of a read word and extends it.
//   rdata_i   : 32-bit word from memory
//   addr_lo_i : byte offset within the word
//   funct3_i  : load width/sign selector (unknown codes behave as lw)
//   data_o    : aligned, sign/zero-extended result
module load_data_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            Lb:      data_o = {{24{byte_sel[7]}}, byte_sel};
            Lbu:     data_o = {24'd0, byte_sel};
            Lh:      data_o = {{16{half_sel[15]}}, half_sel};
            Lhu:     data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Accepts one request at a time from EX/MEM, runs the
// data-memory handshake, aligns load data and returns a registered writeback result.
//   clk, rst                   : clock, synchronous active-high reset
//   req_*/opcode/funct3/addr/wdata/rd/ld_reg _i : request from EX/MEM
//   stall_o                    : freeze upstream while an access is pending
//   mem_*                      : data-memory strobes, address, byte enables, data, response
//   wb_*_o, misalign_o, mem_err_o : one-cycle writeback result to MEM/WB
module load_store_unit
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    input  logic        ld_reg_i,
    output logic        stall_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [3:0]  mem_mbe_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_resp_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_ld_reg_o,
    output logic        misalign_o,
    output logic        mem_err_o
);

    localparam int unsigned    CntW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

    lsu_state_t      state_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [4:0]      rd_q;
    logic            ld_reg_q;

    logic [31:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic        mem_read_q, mem_write_q, wb_valid_q, wb_ld_reg_q, misalign_q, mem_err_q;
    logic [3:0]  mbe_q;
    logic [4:0]  wb_rd_q;

    logic        is_load_in, is_store_in, req_is_mem, req_misal;
    logic [31:0] ld_data;

    assign is_load_in  = opcode_i == OpLoad;
    assign is_store_in = opcode_i == OpStore;
    assign req_is_mem  = is_load_in | is_store_in;
    assign req_misal   = is_misaligned(is_store_in, funct3_i, addr_i[1:0]);
    assign cnt_d       = cnt_q + 1'b1;

    // RESP accepts like IDLE, so only ACCESS (or an aligned access being accepted) stalls.
    assign stall_o = (state_q == StAccess) | (req_valid_i & req_is_mem & ~req_misal);

    load_data_align u_align (
        .rdata_i   (mem_rdata_i),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .data_o    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            rd_q        <= 5'd0;
            ld_reg_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mbe_q       <= 4'd0;
            mem_wdata_q <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            wb_ld_reg_q <= 1'b0;
            misalign_q  <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            mem_err_q  <= 1'b0;
            case (state_q)
                StIdle, StResp: begin
                    state_q <= StIdle;
                    if (req_valid_i) begin
                        if (!req_is_mem) begin
                            wb_valid_q  <= 1'b1;
                            wb_rd_q     <= rd_i;
                            wb_data_q   <= addr_i;
                            wb_ld_reg_q <= ld_reg_i;
                        end else if (req_misal) begin
                            wb_valid_q  <= 1'b1;
                            misalign_q  <= 1'b1;
                            wb_rd_q     <= rd_i;
                            wb_data_q   <= 32'd0;
                            wb_ld_reg_q <= 1'b0;
                        end else begin
                            state_q     <= StAccess;
                            cnt_q       <= '0;
                            is_store_q  <= is_store_in;
                            funct3_q    <= funct3_i;
                            addr_lo_q   <= addr_i[1:0];
                            rd_q        <= rd_i;
                            ld_reg_q    <= ld_reg_i;
                            mem_addr_q  <= {addr_i[31:2], 2'b00};
                            mem_read_q  <= is_load_in;
                            mem_write_q <= is_store_in;
                            mbe_q       <= is_store_in ? store_mbe(funct3_i, addr_i[1:0])
                                                       : 4'b1111;
                            mem_wdata_q <= store_wdata(funct3_i, wdata_i);
                        end
                    end
                end
                StAccess: begin
                    if (mem_resp_i || (cnt_d == CntMax)) begin
                        state_q     <= StResp;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        wb_valid_q  <= 1'b1;
                        wb_rd_q     <= rd_q;
                        mem_err_q   <= ~mem_resp_i;
                        wb_data_q   <= (mem_resp_i && !is_store_q) ? ld_data : 32'd0;
                        wb_ld_reg_q <= mem_resp_i & ~is_store_q & ld_reg_q;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign mem_mbe_o   = mbe_q;
    assign mem_wdata_o = mem_wdata_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign wb_ld_reg_o = wb_ld_reg_q;
    assign misalign_o  = misalign_q;
    assign mem_err_o   = mem_err_q;

endmodule
